// File: rtl/mw_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mw_adder_pkg
// Description : Definitions shared by the multi-word adder. Provides the limb
//               width, the controller state encoding and a width helper for
//               the limb index counter.
// Revision    : 1.0 - initial release
// ============================================================================
package mw_adder_pkg;

  localparam int LIMB_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } mw_state_t;

  // Bits needed to index n limbs. Never returns less than 1 so that
  // the counter always has a legal declared width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage : mw_adder_pkg
`default_nettype wire

// File: rtl/mw_adder_cla32.sv
`default_nettype none
// ============================================================================
// Module      : CLA32
// Description : 32-bit block carry-lookahead adder with no carry input.
//               Eight 4-bit groups each resolve their internal carries with
//               full lookahead and export group generate/propagate terms.
//               The group carries are then formed from those terms.
// Ports       : a [31:0] - operand A
//               b [31:0] - operand B
//               s [32:0] - a + b, s[32] is the carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module CLA32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [32:0] s
);

  localparam int GRP_W = 4;
  localparam int N_GRP = 32 / GRP_W;

  logic [N_GRP-1:0] grp_g;   // group generate
  logic [N_GRP-1:0] grp_p;   // group propagate
  logic [N_GRP:0]   grp_c;   // carry into each group, grp_c[N_GRP] is carry-out
  logic [31:0]      sum_bits;

  genvar j;
  generate
    for (j = 0; j < N_GRP; j = j + 1) begin : g_grp
      logic [GRP_W-1:0] g;
      logic [GRP_W-1:0] p;
      logic [GRP_W-1:0] c;

      assign g = a[j*GRP_W +: GRP_W] & b[j*GRP_W +: GRP_W];
      assign p = a[j*GRP_W +: GRP_W] ^ b[j*GRP_W +: GRP_W];

      // Internal carries expanded in two-level form from the group carry-in.
      assign c[0] = grp_c[j];
      assign c[1] = g[0] | (p[0] & grp_c[j]);
      assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & grp_c[j]);
      assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & grp_c[j]);

      assign grp_g[j] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                      | (p[3] & p[2] & p[1] & g[0]);
      assign grp_p[j] = &p;

      assign sum_bits[j*GRP_W +: GRP_W] = p ^ c;
    end
  endgenerate

  // Group carries depend only on group G/P, never on the group sums.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = 1'b0;
    for (int k = 0; k < N_GRP; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
  end

  assign s = {grp_c[N_GRP], sum_bits};

endmodule : CLA32
`default_nettype wire

// File: rtl/mw_adder.sv
`default_nettype none
// ============================================================================
// Module      : mw_adder
// Description : Sequential multi-word adder. Streams LIMBS 32-bit limbs, one
//               per cycle, through a pair of CLA32 adders and chains the
//               carry between cycles to form a 32*LIMBS-bit sum.
// Ports       : clk   - clock, rising edge
//               rst   - synchronous active-high reset
//               start - request a new addition (honoured while not busy)
//               a, b  - 32*LIMBS-bit operands, captured on acceptance
//               busy  - limbs are being processed
//               done  - one-cycle pulse, sum is final
//               sum   - 32*LIMBS+1-bit result, MSB is the carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module mw_adder
  import mw_adder_pkg::*;
#(
  parameter int LIMBS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LIMB_W*LIMBS-1:0] a,
  input  logic [LIMB_W*LIMBS-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [LIMB_W*LIMBS:0]   sum
);

  localparam int OP_W  = LIMB_W * LIMBS;
  localparam int IDX_W = clog2(LIMBS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LIMBS - 1);

  mw_state_t         state_q, state_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic              carry_q, carry_d;
  logic [OP_W-1:0]   a_q,     a_d;
  logic [OP_W-1:0]   b_q,     b_d;
  logic [OP_W:0]     sum_q,   sum_d;

  logic [LIMB_W-1:0] a_limb;
  logic [LIMB_W-1:0] b_limb;
  logic [LIMB_W:0]   s0;
  logic [LIMB_W:0]   s1;
  logic              carry_nxt;
  logic              accept;

  // Limb select from the captured operands.
  assign a_limb = a_q[idx_q*LIMB_W +: LIMB_W];
  assign b_limb = b_q[idx_q*LIMB_W +: LIMB_W];

  // First adder sums the limbs; second injects the chained carry.
  CLA32 u_cla_limb (
    .a (a_limb),
    .b (b_limb),
    .s (s0)
  );

  CLA32 u_cla_carry (
    .a (s0[LIMB_W-1:0]),
    .b ({{(LIMB_W-1){1'b0}}, carry_q}),
    .s (s1)
  );

  // At most one of the two adders can carry out: if the limb sum wrapped,
  // its low half is at most 2^32-2, so adding one more cannot wrap again.
  assign carry_nxt = s0[LIMB_W] | s1[LIMB_W];

  assign accept = (state_q != ADD) && start;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[idx_q*LIMB_W +: LIMB_W] = s1[LIMB_W-1:0];
        carry_d = carry_nxt;
        if (idx_q == LAST_IDX) begin
          sum_d[OP_W] = carry_nxt;
          idx_d       = '0;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = start ? ADD : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      a_d     = a;
      b_d     = b;
      idx_d   = '0;
      carry_d = 1'b0;
      sum_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign busy = (state_q == ADD);
  assign done = (state_q == DONE);
  assign sum  = sum_q;

endmodule : mw_adder
`default_nettype wire

// File: tb/tb_mw_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mw_adder
// Description : Directed self-checking bench for mw_adder with LIMBS=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mw_adder;

  localparam int LIMBS = 4;
  localparam int W     = 32 * LIMBS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W:0]   sum;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mw_adder #(.LIMBS(LIMBS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum)
  );

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation and follow it cycle by cycle to its done pulse.
  task automatic run_op(input string tag, input logic [W-1:0] op_a,
                        input logic [W-1:0] op_b, input logic [W:0] exp);
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < LIMBS; i++) begin
      check({tag, " busy/done"}, {127'd0, busy, done}, 129'b10);
      step();
    end
    check({tag, " done pulse"}, {127'd0, busy, done}, 129'b01);
    check({tag, " sum"}, sum, exp);
    step();
    check({tag, " back idle"}, {127'd0, busy, done}, 129'b00);
    check({tag, " sum held"}, sum, exp);
  endtask

  initial begin
    logic         saw_done;
    logic [W-1:0] ones;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W:0]   rexp;

    ones  = '1;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Reset state after two reset cycles.
    step();
    step();
    check("reset busy", {128'd0, busy}, 129'd0);
    check("reset done", {128'd0, done}, 129'd0);
    check("reset sum", sum, 129'd0);
    rst = 1'b0;
    step();

    // Reset held two cycles during an active addition.
    a     = ones;
    b     = ones;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst mid-add outputs", {126'd0, busy, done, |sum}, 129'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      saw_done = saw_done | done | busy;
    end
    check("rst mid-add no done", {128'd0, saw_done}, 129'd0);

    // Carry ripples through every limb into bit 128.
    run_op("all-ones+1", ones, 128'd1, 129'd1 << 128);

    // Single carry from limb 0 into limb 1 only.
    run_op("limb0 carry", 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1,
           129'h1_0000_0000);

    // A start pulse while busy must not disturb the running addition.
    a     = 128'd5;
    b     = 128'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    a     = ones;
    b     = ones;
    start = 1'b1;
    step();
    start = 1'b0;
    check("ignore busy", {128'd0, busy}, 129'd1);
    step();
    check("ignore done", {127'd0, busy, done}, 129'b01);
    check("ignore sum", sum, 129'd12);
    step();
    check("ignore idle", {127'd0, busy, done}, 129'b00);

    // Reset while processing limb index 2, then a clean operation.
    a     = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    b     = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst limb2 outputs", {127'd0, busy, done}, 129'd0);
    check("rst limb2 sum", sum, 129'd0);
    run_op("after rst", 128'h8000_0000_0000_0000_8000_0000_8000_0000,
           128'h8000_0000_0000_0000_8000_0000_8000_0000,
           129'h1_0000_0000_0000_0001_0000_0001_0000_0000);

    // Back-to-back operations with start held high.
    start = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (n == 0) begin
        ra = ones;
        rb = ones;
      end else begin
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
      end
      rexp = {1'b0, ra} + {1'b0, rb};
      a    = ra;
      b    = rb;
      step();
      for (int j = 0; j < LIMBS; j++) begin
        check("stream busy", {127'd0, busy, done}, 129'b10);
        step();
      end
      check("stream done", {127'd0, busy, done}, 129'b01);
      check("stream sum", sum, rexp);
    end
    start = 1'b0;
    step();
    check("stream end idle", {127'd0, busy, done}, 129'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mw_adder
`default_nettype wire
